if_fetch_unit: RTL and testbench

IF-stage fetch unit that sources the ID stage. It owns the PC register and drives the synchronous instruction SRAM port. It produces the IF→ID bus {ce, pc} and a stall-safe instruction word to ID. It consumes ID's branch bus {br_e, br_addr} and keeps a taken branch that arrives while the PC is stalled, so the redirect is never lost.

---
 rtl/if_fetch_unit_if.sv | 24 ++
 rtl/if_fetch_unit.sv | 100 ++++++++++
 tb/tb_if_fetch_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// IF-stage bus bundle: stall/branch inputs from the pipeline, IF->ID bus and instruction SRAM port.
interface if_fetch_unit_if;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [31:0] inst_sram_rdata;
    logic [32:0] if_to_id_bus;
    logic [31:0] id_inst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;

    modport master (
        input  stall, br_bus, inst_sram_rdata,
        output if_to_id_bus, id_inst, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output stall, br_bus, inst_sram_rdata,
        input  if_to_id_bus, id_inst, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: owns the PC, drives the instruction SRAM, keeps branches that
// arrive during a PC stall and holds the instruction word stable while IF/ID is stalled.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_unit_if.master bus
);
    localparam int unsigned ADDR_W = 32;
    localparam logic [0:0]  BP_IDLE = 1'b0;
    localparam logic [0:0]  BP_PEND = 1'b1;

    logic [ADDR_W-1:0] pc_r, pc_nxt;
    logic              ce_r, ce_nxt;
    logic [0:0]        bp_state, bp_state_nxt;
    logic [ADDR_W-1:0] bp_addr, bp_addr_nxt;
    logic              ib_valid, ib_valid_nxt;
    logic [31:0]       ib_data, ib_data_nxt;

    logic              bp_valid;
    logic              br_e;
    logic [ADDR_W-1:0] br_addr;
    logic [ADDR_W-1:0] next_pc;
    logic              pc_stop;
    logic              ib_stop;
    logic              unused_stall;

    assign br_e         = bus.br_bus[32];
    assign br_addr      = bus.br_bus[31:0];
    assign pc_stop      = bus.stall[0];
    assign ib_stop      = bus.stall[1];
    assign unused_stall = ^bus.stall[5:2];
    assign bp_valid     = (bp_state == BP_PEND);

    // Fresh branch beats a pending one, which beats sequential fetch; always word aligned.
    always_comb begin
        next_pc = pc_r + PC_STEP;
        if (br_e) begin
            next_pc = br_addr;
        end else if (bp_valid) begin
            next_pc = bp_addr;
        end
        next_pc[1:0] = 2'b00;
    end

    // Next-state logic for PC, pending branch and instruction hold buffer.
    always_comb begin
        pc_nxt       = pc_r;
        ce_nxt       = ce_r;
        bp_state_nxt = bp_state;
        bp_addr_nxt  = bp_addr;
        ib_valid_nxt = ib_valid;
        ib_data_nxt  = ib_data;

        if (!pc_stop) begin
            pc_nxt       = next_pc;
            ce_nxt       = 1'b1;
            bp_state_nxt = BP_IDLE;
        end else if (br_e) begin
            bp_state_nxt = BP_PEND;
            bp_addr_nxt  = {br_addr[ADDR_W-1:2], 2'b00};
        end

        if (ib_stop) begin
            if (!ib_valid) begin
                ib_valid_nxt = 1'b1;
                ib_data_nxt  = bus.inst_sram_rdata;
            end
        end else begin
            ib_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r     <= RESET_PC - PC_STEP;
            ce_r     <= 1'b0;
            bp_state <= BP_IDLE;
            bp_addr  <= '0;
            ib_valid <= 1'b0;
            ib_data  <= '0;
        end else begin
            pc_r     <= pc_nxt;
            ce_r     <= ce_nxt;
            bp_state <= bp_state_nxt;
            bp_addr  <= bp_addr_nxt;
            ib_valid <= ib_valid_nxt;
            ib_data  <= ib_data_nxt;
        end
    end

    assign bus.if_to_id_bus    = {ce_r, pc_r};
    assign bus.inst_sram_en    = ce_r;
    assign bus.inst_sram_addr  = pc_r;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_wdata = 32'h0000_0000;
    assign bus.id_inst         = ib_valid ? ib_data : bus.inst_sram_rdata;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, async-reset sequence, random run vs reference model.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0]  stall;
        logic        br_e;
        logic [31:0] br_addr;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic        exp_ce;
        logic [31:0] exp_inst;
        logic        exp_bp;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: pending branch and held instruction kept as 0/1-entry queues.
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] m_pend[$];
    logic [31:0] m_hold[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] st, input logic be, input logic [31:0] ba,
                                input logic [31:0] rd, input logic [31:0] pc, input logic ce,
                                input logic [31:0] inst, input logic bp);
        vec_t v;
        v.stall = st; v.br_e = be; v.br_addr = ba; v.rdata = rd;
        v.exp_pc = pc; v.exp_ce = ce; v.exp_inst = inst; v.exp_bp = bp;
        return v;
    endfunction

    task automatic drive(input logic [5:0] st, input logic be, input logic [31:0] ba,
                         input logic [31:0] rd);
        bus.stall           = st;
        bus.br_bus          = {be, ba};
        bus.inst_sram_rdata = rd;
    endtask

    task automatic model_reset();
        m_pc = 32'hBFC0_0000 - 32'd4;
        m_ce = 1'b0;
        m_pend.delete();
        m_hold.delete();
    endtask

    task automatic model_step(input logic [5:0] st, input logic be, input logic [31:0] ba,
                              input logic [31:0] rd);
        logic [31:0] target;
        if (be)                  target = ba;
        else if (m_pend.size())  target = m_pend[0];
        else                     target = m_pc + 32'd4;
        target = target & 32'hFFFF_FFFC;
        if (!st[0]) begin
            m_pc = target;
            m_ce = 1'b1;
            m_pend.delete();
        end else if (be) begin
            m_pend.delete();
            m_pend.push_back(ba & 32'hFFFF_FFFC);
        end
        if (st[1]) begin
            if (m_hold.size() == 0) m_hold.push_back(rd);
        end else begin
            m_hold.delete();
        end
    endtask

    task automatic check_model(input string tag, input logic [31:0] rd);
        check({tag, " pc"},   bus.if_to_id_bus[31:0], m_pc);
        check({tag, " ce"},   32'(bus.if_to_id_bus[32]), 32'(m_ce));
        check({tag, " en"},   32'(bus.inst_sram_en), 32'(m_ce));
        check({tag, " addr"}, bus.inst_sram_addr, m_pc);
        check({tag, " inst"}, bus.id_inst, (m_hold.size() != 0) ? m_hold[0] : rd);
        check({tag, " bp"},   32'(dut.bp_valid), 32'(m_pend.size() != 0));
    endtask

    task automatic check_reset_outputs(input string tag, input logic [31:0] rd);
        check({tag, " pc"},    bus.if_to_id_bus[31:0], 32'hBFBF_FFFC);
        check({tag, " ce"},    32'(bus.if_to_id_bus[32]), 32'd0);
        check({tag, " en"},    32'(bus.inst_sram_en), 32'd0);
        check({tag, " addr"},  bus.inst_sram_addr, 32'hBFBF_FFFC);
        check({tag, " wen"},   32'(bus.inst_sram_wen), 32'd0);
        check({tag, " wdata"}, bus.inst_sram_wdata, 32'd0);
        check({tag, " inst"},  bus.id_inst, rd);
        check({tag, " bp"},    32'(dut.bp_valid), 32'd0);
        check({tag, " ib"},    32'(dut.ib_valid), 32'd0);
    endtask

    initial begin
        drive(6'd0, 1'b0, 32'd0, 32'h1234_5678);
        rst = 1'b0;

        // Boot: reset held for three edges with stall=0.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_reset_outputs("reset", 32'h1234_5678);
        end
        rst = 1'b1;

        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_0001, 32'hBFC0_0000, 1, 32'hA000_0001, 0));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_0002, 32'hBFC0_0004, 1, 32'hA000_0002, 0));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_0003, 32'hBFC0_0008, 1, 32'hA000_0003, 0));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_0004, 32'hBFC0_000C, 1, 32'hA000_0004, 0));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_0005, 32'hBFC0_0010, 1, 32'hA000_0005, 0));
        vecs.push_back(mk(6'd0, 1, 32'hBFC0_0100, 32'hA000_0006, 32'hBFC0_0100, 1, 32'hA000_0006, 0));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_0007, 32'hBFC0_0104, 1, 32'hA000_0007, 0));
        vecs.push_back(mk(6'd3, 1, 32'hBFC0_0200, 32'hA000_0008, 32'hBFC0_0104, 1, 32'hA000_0008, 1));
        vecs.push_back(mk(6'd3, 0, 32'd0,         32'hA000_0009, 32'hBFC0_0104, 1, 32'hA000_0008, 1));
        vecs.push_back(mk(6'd3, 0, 32'd0,         32'hA000_000A, 32'hBFC0_0104, 1, 32'hA000_0008, 1));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_000B, 32'hBFC0_0200, 1, 32'hA000_000B, 0));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_000C, 32'hBFC0_0204, 1, 32'hA000_000C, 0));
        vecs.push_back(mk(6'd2, 0, 32'd0,         32'h3C01_0001, 32'hBFC0_0208, 1, 32'h3C01_0001, 0));
        vecs.push_back(mk(6'd2, 0, 32'd0,         32'h2421_0002, 32'hBFC0_020C, 1, 32'h3C01_0001, 0));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'h2421_0002, 32'hBFC0_0210, 1, 32'h2421_0002, 0));
        vecs.push_back(mk(6'd0, 1, 32'hFFFF_FFFE, 32'hA000_0010, 32'hFFFF_FFFC, 1, 32'hA000_0010, 0));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_0011, 32'h0000_0000, 1, 32'hA000_0011, 0));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_0012, 32'h0000_0004, 1, 32'hA000_0012, 0));
        vecs.push_back(mk(6'd1, 1, 32'h0000_1000, 32'hA000_0013, 32'h0000_0004, 1, 32'hA000_0013, 1));
        vecs.push_back(mk(6'd1, 1, 32'h0000_2001, 32'hA000_0014, 32'h0000_0004, 1, 32'hA000_0014, 1));
        vecs.push_back(mk(6'd0, 1, 32'h0000_3000, 32'hA000_0015, 32'h0000_3000, 1, 32'hA000_0015, 0));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_0016, 32'h0000_3004, 1, 32'hA000_0016, 0));
        vecs.push_back(mk(6'd1, 1, 32'h0000_5000, 32'hA000_0017, 32'h0000_3004, 1, 32'hA000_0017, 1));
        vecs.push_back(mk(6'd1, 1, 32'h0000_6003, 32'hA000_0018, 32'h0000_3004, 1, 32'hA000_0018, 1));
        vecs.push_back(mk(6'd0, 0, 32'd0,         32'hA000_0019, 32'h0000_6000, 1, 32'hA000_0019, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].br_e, vecs[i].br_addr, vecs[i].rdata);
            @(posedge clk); #1;
            check($sformatf("vec%0d pc", i),   bus.if_to_id_bus[31:0], vecs[i].exp_pc);
            check($sformatf("vec%0d ce", i),   32'(bus.if_to_id_bus[32]), 32'(vecs[i].exp_ce));
            check($sformatf("vec%0d en", i),   32'(bus.inst_sram_en), 32'(vecs[i].exp_ce));
            check($sformatf("vec%0d inst", i), bus.id_inst, vecs[i].exp_inst);
            check($sformatf("vec%0d bp", i),   32'(dut.bp_valid), 32'(vecs[i].exp_bp));
        end

        // Async reset between edges with a pending branch and a held instruction.
        drive(6'd3, 1'b1, 32'h0000_7000, 32'h55AA_55AA);
        @(posedge clk); #1;
        check("pre-arst bp", 32'(dut.bp_valid), 32'd1);
        check("pre-arst ib", 32'(dut.ib_valid), 32'd1);
        drive(6'd3, 1'b0, 32'd0, 32'h6677_8899);
        #2 rst = 1'b0;
        #1 check_reset_outputs("arst", 32'h6677_8899);
        @(posedge clk); #1;
        check_reset_outputs("arst hold", 32'h6677_8899);
        drive(6'd0, 1'b0, 32'd0, 32'h0BAD_F00D);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        model_step(6'd0, 1'b0, 32'd0, 32'h0BAD_F00D);
        check_model("arst boot", 32'h0BAD_F00D);

        // Random run against the reference model.
        for (int c = 0; c < 400; c++) begin
            logic [5:0]  st;
            logic        be;
            logic [31:0] ba, rd;
            st = {4'($urandom), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 2) == 0) st[1:0] = 2'b00;
            be = ($urandom_range(0, 4) == 0);
            ba = $urandom;
            if ($urandom_range(0, 7) == 0) ba = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            rd = $urandom;
            drive(st, be, ba, rd);
            @(posedge clk); #1;
            model_step(st, be, ba, rd);
            check_model($sformatf("rand%0d", c), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
